// File: rtl/mic_pkg.sv
// Shared types and constants for the microphone-to-colour front end.
package mic_pkg;
    localparam logic [11:0] MID_SCALE      = 12'h800;
    localparam int          ADC_FRAME_BITS = 16;
    localparam int          ADC_LEAD_ZEROS = 4;

    typedef logic [11:0] rgb444_t;

    typedef enum logic [1:0] {IDLE, CONV, QUIET} spi_state_t;

    // Green at silence, red at full scale.
    function automatic rgb444_t level_to_rgb(input logic [3:0] level);
        return {level, 4'hF - level, 4'h0};
    endfunction
endpackage

// File: rtl/spi_adc_reader.sv
// ADCS7476 reader: fixed-rate conversion starts, SPI frame generation and
// capture of the 12 data bits that follow the leading zeros.
module spi_adc_reader
    import mic_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int QUIET_CYCLES  = 8,
    parameter int SAMPLE_PERIOD = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miso,
    output logic        sclk,
    output logic        cs_n,
    output logic        sample_valid,
    output logic [11:0] sample
);
    localparam int TW       = $clog2(SAMPLE_PERIOD);
    localparam int DW       = $clog2(CLK_DIV);
    localparam int QW       = $clog2(QUIET_CYCLES + 1);
    localparam int EW       = $clog2(2 * ADC_FRAME_BITS);
    localparam int SAMPLE_W = ADC_FRAME_BITS - ADC_LEAD_ZEROS;

    spi_state_t            state_q, state_d;
    logic [TW-1:0]         timer_q;
    logic [DW-1:0]         div_q, div_d;
    logic [EW-1:0]         tog_q, tog_d;
    logic [QW-1:0]         quiet_q, quiet_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic [SAMPLE_W-1:0]   shreg_q, shreg_d;
    logic                  done_q, done_d;
    logic [11:0]           sample_q;
    logic                  sample_valid_q;
    logic                  tick;

    assign tick = (timer_q == TW'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) timer_q <= '0;
        else      timer_q <= tick ? '0 : timer_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tog_d   = tog_q;
        quiet_d = quiet_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (tick) begin
                state_d = CONV;
                cs_n_d  = 1'b0;
                sclk_d  = 1'b1;
                div_d   = '0;
                tog_d   = '0;
            end
            CONV: if (div_q == DW'(CLK_DIV - 1)) begin
                div_d  = '0;
                sclk_d = ~sclk_q;
                tog_d  = tog_q + 1'b1;
                // Leading zeros shift out the top of the 12-bit register.
                if (!sclk_q) shreg_d = {shreg_q[SAMPLE_W-2:0], miso};
                if (tog_q == EW'(2 * ADC_FRAME_BITS - 1)) begin
                    state_d = QUIET;
                    cs_n_d  = 1'b1;
                    quiet_d = '0;
                    done_d  = 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
            QUIET: begin
                if (quiet_q == QW'(QUIET_CYCLES - 1)) state_d = IDLE;
                else                                  quiet_d = quiet_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            div_q          <= '0;
            tog_q          <= '0;
            quiet_q        <= '0;
            sclk_q         <= 1'b1;
            cs_n_q         <= 1'b1;
            shreg_q        <= '0;
            done_q         <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            tog_q          <= tog_d;
            quiet_q        <= quiet_d;
            sclk_q         <= sclk_d;
            cs_n_q         <= cs_n_d;
            shreg_q        <= shreg_d;
            done_q         <= done_d;
            sample_valid_q <= done_q;
            if (done_q) sample_q <= shreg_q;
        end
    end

    assign sclk         = sclk_q;
    assign cs_n         = cs_n_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
endmodule

// File: rtl/mic_color_source.sv
// Microphone front end: peak amplitude over a window of ADC samples mapped
// to one RGB444 colour for the VGA controller.
module mic_color_source
    import mic_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int QUIET_CYCLES  = 8,
    parameter int SAMPLE_PERIOD = 2500,
    parameter int WINDOW        = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miso,
    output logic        sclk,
    output logic        cs_n,
    output logic        sample_valid,
    output logic [11:0] sample,
    output logic        color_valid,
    output rgb444_t     color
);
    localparam int WW = $clog2(WINDOW);

    logic [11:0]   diff;
    logic [10:0]   amp_d, amp_q, peak_q, pmax;
    logic          amp_vld_q;
    logic [WW-1:0] win_q;
    rgb444_t       color_q;
    logic          color_valid_q;

    spi_adc_reader #(
        .CLK_DIV       (CLK_DIV),
        .QUIET_CYCLES  (QUIET_CYCLES),
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_adc (
        .clk          (clk),
        .rst          (rst),
        .miso         (miso),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .sample_valid (sample_valid),
        .sample       (sample)
    );

    // Full negative scale (2048) does not fit in 11 bits; clamp it.
    always_comb begin
        diff  = (sample >= MID_SCALE) ? sample - MID_SCALE : MID_SCALE - sample;
        amp_d = diff[11] ? 11'h7FF : diff[10:0];
    end

    assign pmax = (amp_q > peak_q) ? amp_q : peak_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            amp_q         <= '0;
            amp_vld_q     <= 1'b0;
            peak_q        <= '0;
            win_q         <= '0;
            color_q       <= '0;
            color_valid_q <= 1'b0;
        end else begin
            amp_vld_q     <= sample_valid;
            color_valid_q <= 1'b0;
            if (sample_valid) amp_q <= amp_d;
            if (amp_vld_q) begin
                if (win_q == WW'(WINDOW - 1)) begin
                    win_q         <= '0;
                    peak_q        <= '0;
                    color_q       <= level_to_rgb(pmax[10:7]);
                    color_valid_q <= 1'b1;
                end else begin
                    win_q  <= win_q + 1'b1;
                    peak_q <= pmax;
                end
            end
        end
    end

    assign color       = color_q;
    assign color_valid = color_valid_q;
endmodule

// File: tb/tb_mic_color_source.sv
// Directed bench for mic_color_source with a behavioural ADCS7476 model.
module tb_mic_color_source;
    localparam int CD = 2;
    localparam int QC = 4;
    localparam int SP = 80;
    localparam int W  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miso = 1'b0;
    logic        sclk, cs_n, sample_valid, color_valid;
    logic [11:0] sample, color;

    int n_cmp = 0;
    int n_bad = 0;

    mic_color_source #(
        .CLK_DIV(CD), .QUIET_CYCLES(QC), .SAMPLE_PERIOD(SP), .WINDOW(W)
    ) dut (
        .clk(clk), .rst(rst), .miso(miso), .sclk(sclk), .cs_n(cs_n),
        .sample_valid(sample_valid), .sample(sample),
        .color_valid(color_valid), .color(color)
    );

    always #5 clk = ~clk;

    // ADC model: one queued word per frame (mid-scale when empty), MSB first on sclk falls.
    logic [11:0] wq[$];
    logic [3:0]  lq[$];
    logic [15:0] frame = 16'h0800;
    int          bidx = -1;

    always @(negedge cs_n) begin
        if (wq.size() > 0) frame = {lq.pop_front(), wq.pop_front()};
        else               frame = 16'h0800;
        bidx = 15;
    end

    always @(negedge sclk) begin
        if (!cs_n && bidx >= 0) begin
            miso = frame[bidx];
            bidx--;
        end
    end

    typedef struct {
        logic [11:0] word;
        logic [3:0]  lead;
        logic [11:0] exp;
    } svec_t;

    typedef struct {
        logic [3:0][11:0] w;
        logic [11:0]      exp;
    } wvec_t;

    svec_t sv[5];
    wvec_t wv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_sv(input string nm);
        bit ok = 0;
        for (int i = 0; i < 3 * SP; i++) begin
            @(negedge clk);
            if (sample_valid) begin ok = 1; break; end
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_cs_low(input string nm);
        bit ok = 0;
        for (int i = 0; i < 3 * SP; i++) begin
            @(negedge clk);
            if (!cs_n) begin ok = 1; break; end
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
    endtask

    // Waits for color_valid, counting sample strobes seen on the way.
    task automatic wait_color(input string nm, output int nsv);
        bit ok = 0;
        nsv = 0;
        for (int i = 0; i < (W + 3) * SP; i++) begin
            @(negedge clk);
            if (sample_valid) nsv++;
            if (color_valid) begin ok = 1; break; end
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        int c, lowc, falls, period, nsv;
        bit seen, high, prev;

        sv[0] = '{12'hA5C, 4'h0, 12'hA5C};
        sv[1] = '{12'hA5C, 4'hF, 12'hA5C};
        sv[2] = '{12'h000, 4'h0, 12'h000};
        sv[3] = '{12'hFFF, 4'h5, 12'hFFF};
        sv[4] = '{12'h801, 4'hA, 12'h801};

        wv[0] = '{{12'h800, 12'h800, 12'h800, 12'h800}, 12'h0F0};
        wv[1] = '{{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 12'hF00};
        wv[2] = '{{12'h000, 12'h000, 12'h000, 12'h000}, 12'hF00};
        wv[3] = '{{12'h800, 12'h800, 12'hC00, 12'h800}, 12'h870};
        wv[4] = '{{12'hC00, 12'h800, 12'h800, 12'h800}, 12'h870};
        wv[5] = '{{12'h800, 12'h800, 12'h800, 12'h800}, 12'h0F0};
        wv[6] = '{{12'h800, 12'h800, 12'h800, 12'hA5C}, 12'h4B0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 1);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_sample", sample, 0);
        chk("rst_color_valid", color_valid, 0);
        chk("rst_color", color, 0);

        // First conversion start SP cycles after release
        rst = 1'b1;
        c = 0; seen = 0;
        while (c < SP + 20 && !seen) begin
            @(negedge clk);
            c++;
            if (!cs_n) seen = 1;
        end
        chk("first_tick", c, SP);

        // Frame shape and spacing
        lowc = 1; falls = 0; period = 0; high = 0; prev = sclk;
        seen = 0;
        while (!seen && period < 3 * SP) begin
            @(negedge clk);
            period++;
            if (cs_n) high = 1;
            else if (high) seen = 1;
            else begin
                lowc++;
                if (prev && !sclk) falls++;
            end
            prev = sclk;
        end
        chk("cs_low_cycles", lowc, 32 * CD);
        chk("sclk_falls", falls, 16);
        chk("frame_spacing", period, SP);

        // Sample capture, leading bits ignored
        wait_sv("drain");
        foreach (sv[i]) begin
            wq.push_back(sv[i].word);
            lq.push_back(sv[i].lead);
            wait_sv($sformatf("sample%0d", i));
            chk($sformatf("sample%0d", i), sample, sv[i].exp);
        end

        // Realign the window, then one colour per window
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        foreach (wv[i]) begin
            for (int k = 0; k < W; k++) begin
                wq.push_back(wv[i].w[k]);
                lq.push_back(4'h0);
            end
            wait_color($sformatf("win%0d", i), nsv);
            chk($sformatf("win%0d_color", i), color, wv[i].exp);
            chk($sformatf("win%0d_nsamples", i), nsv, W);
            @(negedge clk);
            chk($sformatf("win%0d_hold", i), {color_valid, color}, {1'b0, wv[i].exp});
        end

        // Part-fill a loud window, then abort a frame mid-way with reset
        for (int k = 0; k < 2; k++) begin
            wq.push_back(12'hFFF);
            lq.push_back(4'h0);
        end
        wait_sv("pre_abort0");
        wait_sv("pre_abort1");
        wait_cs_low("abort_frame");
        repeat (9 * 2 * CD) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 1);
        chk("abort_color_valid", color_valid, 0);
        chk("abort_color", color, 0);
        chk("abort_sample_valid", sample_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < W; k++) begin
            wq.push_back(12'hC00);
            lq.push_back(4'h0);
        end
        wait_color("post_abort", nsv);
        chk("post_abort_nsamples", nsv, W);
        chk("post_abort_color", color, 12'h870);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
